// File: rtl/cam_dbg_pkg.sv
// cam_dbg_pkg
//   Shared definitions for the camera debug capture path: sequencer state
//   encoding and default counter widths.
package cam_dbg_pkg;

  localparam int CAM_LINE_W = 11;
  localparam int CAM_PIX_W  = 12;
  localparam int CAM_NFR_W  = 4;

  typedef enum logic [1:0] {
    SEQ_IDLE    = 2'd0,
    SEQ_WAIT_VS = 2'd1,
    SEQ_ACTIVE  = 2'd2,
    SEQ_DONE    = 2'd3
  } cam_seq_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
//   Two-flop synchroniser for an asynchronous pin followed by registered
//   rise/fall detection. A pin edge before clock edge k gives a one-cycle
//   pulse visible after edge k+1; lvl changes at the same edge.
// Ports
//   clk    in   system clock
//   reset  in   synchronous, active-high
//   in     in   raw asynchronous pin
//   lvl    out  synchronised level
//   rise   out  one-cycle rising-edge pulse
//   fall   out  one-cycle falling-edge pulse
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= in;
      s2   <= s1;
      rise <= s1 & ~s2;
      fall <= ~s1 & s2;
    end
  end

  assign lvl = s2;

endmodule

// File: rtl/cam_capture_sequencer.sv
// cam_capture_sequencer
//   Opens capture_en for exactly num_frames whole sensor frames after an arm
//   request, and counts completed lines and captured pixels per line.
//
//   state   | meaning
//   IDLE    | waiting for arm with a non-zero frame count
//   WAIT_VS | armed; waiting for VSYNC fall to start a whole frame
//   ACTIVE  | frame in progress; capture_en follows synchronised HREF
//   DONE    | last frame ended; done pulses for this cycle
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   arm, abort             one-cycle requests (abort wins)
//   num_frames             frames to capture, sampled on accepted arm
//   vsync_in, href_in      raw sensor pins
//   busy, capture_en       status / pixel qualifier
//   frame_start, frame_end per-frame pulses
//   done                   pulse after the last requested frame
//   line_count             completed lines in current frame (saturating)
//   pixel_count            capture_en cycles in current line (saturating)
module cam_capture_sequencer
  import cam_dbg_pkg::*;
#(
  parameter int LINE_W = CAM_LINE_W,
  parameter int PIX_W  = CAM_PIX_W,
  parameter int NFR_W  = CAM_NFR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic [NFR_W-1:0]  num_frames,
  input  logic              vsync_in,
  input  logic              href_in,
  output logic              busy,
  output logic              capture_en,
  output logic              frame_start,
  output logic              frame_end,
  output logic              done,
  output logic [LINE_W-1:0] line_count,
  output logic [PIX_W-1:0]  pixel_count
);

  localparam logic [1:0] ST_IDLE    = 2'(SEQ_IDLE);
  localparam logic [1:0] ST_WAIT_VS = 2'(SEQ_WAIT_VS);
  localparam logic [1:0] ST_ACTIVE  = 2'(SEQ_ACTIVE);
  localparam logic [1:0] ST_DONE    = 2'(SEQ_DONE);

  logic             vs_lvl, vs_rise, vs_fall;
  logic             href_lvl, href_rise, href_fall;
  logic [1:0]       state, state_nxt;
  logic [NFR_W-1:0] frames_left;
  logic             arm_ok;
  logic             vs_start;

  sync_edge_det u_vsync (
    .clk   (clk),
    .reset (reset),
    .in    (vsync_in),
    .lvl   (vs_lvl),
    .rise  (vs_rise),
    .fall  (vs_fall)
  );

  sync_edge_det u_href (
    .clk   (clk),
    .reset (reset),
    .in    (href_in),
    .lvl   (href_lvl),
    .rise  (href_rise),
    .fall  (href_fall)
  );

  assign arm_ok   = (state == ST_IDLE) && arm && (num_frames != '0);
  // fall and lvl register on the same edge, so this only ties the frame
  // start to the settled low level of VSYNC.
  assign vs_start = vs_fall & ~vs_lvl;

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (arm_ok) state_nxt = ST_WAIT_VS;
        ST_WAIT_VS: if (vs_start) state_nxt = ST_ACTIVE;
        ST_ACTIVE:  if (vs_rise)
                      state_nxt = (frames_left == NFR_W'(1)) ? ST_DONE : ST_WAIT_VS;
        ST_DONE:    state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  assign busy        = (state == ST_WAIT_VS) || (state == ST_ACTIVE);
  assign capture_en  = (state == ST_ACTIVE) && href_lvl;
  assign frame_start = (state == ST_WAIT_VS) && vs_start && !abort;
  assign frame_end   = (state == ST_ACTIVE) && vs_rise && !abort;
  assign done        = (state == ST_DONE) && !abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      frames_left <= '0;
      line_count  <= '0;
      pixel_count <= '0;
    end else begin
      state <= state_nxt;

      if (abort)          frames_left <= '0;
      else if (arm_ok)    frames_left <= num_frames;
      else if (frame_end) frames_left <= frames_left - NFR_W'(1);

      if (frame_start) begin
        line_count  <= '0;
        pixel_count <= '0;
      end else if (state == ST_ACTIVE) begin
        // A new line restarts the count; the rising cycle is itself a
        // captured pixel, so it loads 1 rather than 0.
        if (href_rise)
          pixel_count <= capture_en ? PIX_W'(1) : '0;
        else if (capture_en && (pixel_count != '1))
          pixel_count <= pixel_count + PIX_W'(1);

        if (href_fall && (line_count != '1))
          line_count <= line_count + LINE_W'(1);
      end
    end
  end

endmodule
